uart_echo_fifo: RTL and testbench
=================================

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 The block SHALL have parameter P_UART_DATA_WIDTH, default 8, giving the byte width of the rx and tx data.
REQ-002 The block SHALL have parameter P_FIFO_DEPTH, default 16, giving the buffer depth; legal values are powers of 2 from 2 to 256.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock, i.e. the clock of the UART user interface.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_user_rx_data, input, P_UART_DATA_WIDTH bits: the received byte.
REQ-006 The block SHALL have port i_user_rx_valid, input, 1 bit: a 1-cycle strobe marking i_user_rx_data valid; there is no backpressure.
REQ-007 The block SHALL have port o_user_tx_data, output, P_UART_DATA_WIDTH bits: the byte to transmit.
REQ-008 The block SHALL have port o_user_tx_valid, output, 1 bit: a tx byte is offered.
REQ-009 The block SHALL have port i_user_tx_ready, input, 1 bit: the transmitter can accept a byte.
REQ-010 The block SHALL have port o_fifo_count, output, clog2(P_FIFO_DEPTH)+1 bits: the number of bytes stored, excluding the byte held in the output register.
REQ-011 The block SHALL have port o_overflow, output, 1 bit: a 1-cycle pulse for each dropped rx byte.

Function
REQ-012 The buffer SHALL be a circular FIFO of P_FIFO_DEPTH entries with write and read pointers that wrap modulo P_FIFO_DEPTH.
REQ-013 A push SHALL occur on a cycle with i_user_rx_valid=1 when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 When i_user_rx_valid=1 with the FIFO full and no pop in that cycle, the byte SHALL be discarded, the FIFO SHALL be unchanged, and o_overflow SHALL be 1 on the next cycle.
REQ-015 o_fifo_count SHALL update one cycle after a push or pop: +1 for a push only, -1 for a pop only, unchanged for a simultaneous push and pop.
REQ-016 A transfer SHALL occur on a cycle where o_user_tx_valid=1 and i_user_tx_ready=1.
REQ-017 The transmit FSM SHALL have two states, S_IDLE and S_SEND.
REQ-018 In S_IDLE with o_fifo_count≠0, the FSM SHALL pop the head entry into the o_user_tx_data register and go to S_SEND.
REQ-019 In S_IDLE with o_fifo_count=0, the FSM SHALL remain in S_IDLE.
REQ-020 o_user_tx_valid SHALL be 1 exactly when the FSM is in S_SEND.
REQ-021 In S_SEND without a transfer, o_user_tx_valid and o_user_tx_data SHALL hold stable, regardless of how long i_user_tx_ready stays low.
REQ-022 In S_SEND with a transfer and o_fifo_count≠0, the FSM SHALL pop the next entry into o_user_tx_data and stay in S_SEND, giving back-to-back bytes with no idle cycle.
REQ-023 In S_SEND with a transfer and o_fifo_count=0, the FSM SHALL go to S_IDLE and o_user_tx_valid SHALL fall on the next cycle.
REQ-024 Latency SHALL be: rx strobe at cycle N with an empty FIFO and the FSM in S_IDLE gives o_user_tx_valid=1 with that byte at cycle N+2.
REQ-025 Pop decisions SHALL use the registered count; a byte pushed in cycle N SHALL NOT be popped before cycle N+1.
REQ-026 Byte order SHALL be strict FIFO, with no duplication and no loss except per REQ-014.
REQ-027 i_user_tx_ready=1 while the FSM is in S_IDLE SHALL have no effect.

Reset
REQ-028 While i_rst=1, asynchronously: pointers=0, o_fifo_count=0, FSM=S_IDLE, o_user_tx_valid=0, o_user_tx_data=0, o_overflow=0.
REQ-029 A reset asserted mid-transfer SHALL discard all stored and offered bytes, and no byte received before reset SHALL be transmitted afterwards.
REQ-030 FIFO storage contents need no reset.
REQ-031 After i_rst is released, the first push SHALL be accepted on the first active clock edge.

Verification
REQ-032 Single byte with i_user_tx_ready=1: rx 0xA5 at cycle 0 -> o_user_tx_valid=1 with data 0xA5 at cycle 2, transfer at cycle 2, o_user_tx_valid=0 at cycle 3.
REQ-033 Backpressure: i_user_tx_ready=0 while rx 0x11, 0x22, 0x33 are strobed -> o_user_tx_data=0x11 held stable; then ready=1 -> 0x11, 0x22, 0x33 on 3 consecutive cycles.
REQ-034 Overflow at depth 16 with ready=0: push 18 bytes (0x00-0x11) -> 0x00 in the output register, count=16, one o_overflow pulse for 0x11, none for the 17 accepted bytes; drain -> 0x00-0x10 in order.
REQ-035 Full with simultaneous push and pop: FIFO full, rx strobe on a transfer cycle -> byte accepted, count stays 16, o_overflow=0.
REQ-036 Wrap-around: stream 40 incrementing bytes with ready toggling pseudo-randomly -> output sequence equals input, and count never exceeds 16.
REQ-037 Reset mid-operation: 5 bytes buffered, i_rst pulsed between clock edges -> outputs 0 immediately; after release, rx 0x7E -> only 0x7E is transmitted.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - UART echo buffer: rx strobes into a circular FIFO, drained by a tx handshake FSM
//
// Ports:
//   i_clk            - UART user-interface clock
//   i_rst            - asynchronous active-high reset
//   i_user_rx_data   - received byte
//   i_user_rx_valid  - 1-cycle strobe qualifying i_user_rx_data (no backpressure)
//   o_user_tx_data   - byte offered to the transmitter (output register)
//   o_user_tx_valid  - a tx byte is offered
//   i_user_tx_ready  - transmitter accepts the offered byte
//   o_fifo_count     - bytes stored in the FIFO, excluding the output register
//   o_overflow       - 1-cycle pulse per rx byte dropped because the FIFO was full
`timescale 1ns/1ps

module uart_echo_fifo #(
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH      = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0]   i_user_rx_data,
    input  logic                           i_user_rx_valid,
    output logic [P_UART_DATA_WIDTH-1:0]   o_user_tx_data,
    output logic                           o_user_tx_valid,
    input  logic                           i_user_tx_ready,
    output logic [$clog2(P_FIFO_DEPTH):0]  o_fifo_count,
    output logic                           o_overflow
);

    localparam int LP_AW = $clog2(P_FIFO_DEPTH);
    localparam int LP_CW = LP_AW + 1;
    localparam logic [LP_CW-1:0] LP_FULL = LP_CW'(P_FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;

    logic [P_UART_DATA_WIDTH-1:0]   r_mem [0:P_FIFO_DEPTH-1];
    logic [LP_AW-1:0]               r_wr_ptr;
    logic [LP_AW-1:0]               r_rd_ptr;
    logic [LP_CW-1:0]               r_count;
    logic [P_UART_DATA_WIDTH-1:0]   r_tx_data;
    logic                           r_overflow;

    logic                           w_has_data;
    logic                           w_full;
    logic                           w_xfer;
    logic                           w_pop;
    logic                           w_push;

    // Pop decisions look only at the registered count, so a byte written
    // this cycle can never be read out in the same cycle.
    assign w_has_data = (r_count != '0);
    assign w_full     = (r_count == LP_FULL);
    assign w_xfer     = (r_state == S_SEND) && i_user_tx_ready;

    // A full FIFO still accepts a byte when a pop frees a slot this cycle;
    // the read of the old head and the write into that slot share the edge.
    assign w_push = i_user_rx_valid && (!w_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_has_data) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (w_has_data) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_user_rx_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointer width equals log2(depth), so wrap is the natural rollover.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + LP_AW'(1);
                r_tx_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CW'(1);
                2'b01:   r_count <= r_count - LP_CW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow <= i_user_rx_valid && !w_push;
        end
    end

    assign o_user_tx_data  = r_tx_data;
    assign o_user_tx_valid = (r_state == S_SEND);
    assign o_fifo_count    = r_count;
    assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb/tb_uart_echo_fifo.sv - directed scoreboard testbench for uart_echo_fifo
`timescale 1ns/1ps

module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] fifo_count;
    logic       overflow;

    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_xfer   = 0;
    int         ovf_cnt  = 0;
    int         max_cnt  = 0;
    int         ovf_base;
    int         xfer_base;

    always #5 clk = ~clk;

    uart_echo_fifo #(
        .P_UART_DATA_WIDTH(8),
        .P_FIFO_DEPTH(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_user_rx_data(rx_data),
        .i_user_rx_valid(rx_valid),
        .o_user_tx_data(tx_data),
        .o_user_tx_valid(tx_valid),
        .i_user_tx_ready(tx_ready),
        .o_fifo_count(fifo_count),
        .o_overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        tx_ready = 1'b1;
        for (int i = 0; i < 300 && !(sb.size() == 0 && !tx_valid); i++) begin
            tick;
        end
        chk("drain_done", {31'd0, (sb.size() == 0 && !tx_valid)}, 32'd1);
    endtask

    // Monitor: transfers are compared against the scoreboard at the
    // negedge preceding the accepting clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovf_cnt++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (tx_valid && tx_ready) begin
                n_xfer++;
                chk("unexpected_tx", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    chk("tx_data_order", {24'd0, tx_data}, {24'd0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        #2;
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data",  {24'd0, tx_data},  32'd0);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        tick;
        rst = 1'b0;
        tick;

        // Single byte, ready high throughout
        tx_ready = 1'b1;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        sb.push_back(8'hA5);
        tick;
        rx_valid = 1'b0;
        chk("single_c1_valid", {31'd0, tx_valid}, 32'd0);
        tick;
        chk("single_c2_valid", {31'd0, tx_valid}, 32'd1);
        chk("single_c2_data",  {24'd0, tx_data},  32'hA5);
        tick;
        chk("single_c3_valid", {31'd0, tx_valid}, 32'd0);

        // Backpressure
        tx_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            rx_data  = 8'(i * 8'h11);
            rx_valid = 1'b1;
            sb.push_back(rx_data);
            tick;
        end
        rx_valid = 1'b0;
        repeat (4) tick;
        chk("bp_hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("bp_hold_data",  {24'd0, tx_data},  32'h11);
        chk("bp_count",      {27'd0, fifo_count}, 32'd2);
        tx_ready = 1'b1;
        chk("bp_b2b_0", {24'd0, tx_data}, 32'h11);
        tick;
        chk("bp_b2b_1", {24'd0, tx_data}, 32'h22);
        chk("bp_b2b_1v", {31'd0, tx_valid}, 32'd1);
        tick;
        chk("bp_b2b_2", {24'd0, tx_data}, 32'h33);
        chk("bp_b2b_2v", {31'd0, tx_valid}, 32'd1);
        tick;
        chk("bp_end_valid", {31'd0, tx_valid}, 32'd0);

        // Overflow: 18 bytes with ready low, last one dropped
        tx_ready = 1'b0;
        ovf_base = ovf_cnt;
        for (int i = 0; i < 18; i++) begin
            rx_data  = 8'(i);
            rx_valid = 1'b1;
            if (i < 17) sb.push_back(rx_data);
            tick;
        end
        rx_valid = 1'b0;
        chk("ovf_pulse",       {31'd0, overflow}, 32'd1);
        chk("ovf_none_early",  32'(ovf_cnt - ovf_base), 32'd0);
        tick;
        chk("ovf_pulse_end",   {31'd0, overflow}, 32'd0);
        chk("ovf_pulse_count", 32'(ovf_cnt - ovf_base), 32'd1);
        chk("ovf_count_full",  {27'd0, fifo_count}, 32'd16);
        chk("ovf_out_reg",     {24'd0, tx_data},  32'h00);
        chk("ovf_out_valid",   {31'd0, tx_valid}, 32'd1);

        // Full FIFO: push coinciding with a transfer is accepted
        ovf_base = ovf_cnt;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        tx_ready = 1'b1;
        sb.push_back(8'h55);
        tick;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        chk("full_pp_ovf",   {31'd0, overflow}, 32'd0);
        chk("full_pp_count", {27'd0, fifo_count}, 32'd16);
        chk("full_pp_next",  {24'd0, tx_data},  32'h01);
        tick;
        drain;
        chk("full_pp_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);

        // Wrap-around stream with random ready
        ovf_base = ovf_cnt;
        max_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            rx_data  = 8'(8'h80 + i);
            rx_valid = 1'b1;
            sb.push_back(rx_data);
            tx_ready = ($urandom_range(0, 3) != 0);
            tick;
            rx_valid = 1'b0;
            tx_ready = ($urandom_range(0, 3) != 0);
            tick;
        end
        drain;
        chk("wrap_max_count", {31'd0, (max_cnt <= 16)}, 32'd1);
        chk("wrap_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);

        // Reset mid-operation
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_data  = 8'(8'hC0 + i);
            rx_valid = 1'b1;
            sb.push_back(rx_data);
            tick;
        end
        rx_valid = 1'b0;
        repeat (2) tick;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_data",  {24'd0, tx_data},  32'd0);
        chk("mid_rst_count", {27'd0, fifo_count}, 32'd0);
        chk("mid_rst_ovf",   {31'd0, overflow}, 32'd0);
        sb.delete();
        #3;
        rst = 1'b0;
        xfer_base = n_xfer;
        tick;
        tx_ready = 1'b1;
        rx_data  = 8'h7E;
        rx_valid = 1'b1;
        sb.push_back(8'h7E);
        tick;
        rx_valid = 1'b0;
        chk("post_rst_count", {27'd0, fifo_count}, 32'd1);
        drain;
        chk("post_rst_xfers", 32'(n_xfer - xfer_base), 32'd1);
        repeat (3) tick;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
